i2s_sample_receiver: RTL

- Front end of the level-meter pipeline. Deserialises an external I2S stream (bit clock, LR clock, serial data), all oversampled in the system clock domain.
- Emits one parallel sample per channel slot on a valid/ready stream tagged with left/right. This is the producer of the sample/is-left stream that feeds section_maximum_value.

---
 rtl/i2s_sample_receiver.sv | 130 +++++++++++++
 1 files changed

// File: rtl/i2s_sample_receiver.sv
// i2s_sample_receiver
// Deserialises an oversampled I2S stream (bclk, lrclk, data) into one parallel
// sample per channel slot, presented on a valid/ready stream tagged left/right.
// Default build: standard I2S, where the MSB follows the lrclk change by one bclk.
// Define I2S_LEFT_JUSTIFIED_EN for left-justified framing (MSB on the lrclk change edge).
// The port list is identical in both builds.
module i2s_sample_receiver #(
    parameter int width       = 16,
    parameter int sync_stages = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_bclk,
    input  logic             i_lrclk,
    input  logic             i_data,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [width-1:0] o_value,
    output logic             o_is_left,
    output logic             o_overrun
);

    localparam int cnt_w = $clog2(width + 1);

    logic [sync_stages-1:0] bclk_sync;
    logic [sync_stages-1:0] lrclk_sync;
    logic [sync_stages-1:0] data_sync;
    logic                   bclk_prev;

    logic                   lr_prev;
    logic                   aligned;
    logic [cnt_w-1:0]       bit_cnt;
    logic [width-1:0]       shift_reg;

    logic                   bclk_s;
    logic                   lr;
    logic                   d;
    logic                   bclk_rise;
    logic                   word_done;
    logic [width-1:0]       d_word;
    logic [width-1:0]       done_word;

    // Bring the three pins into the clk domain and keep the last synchronised bclk level.
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bclk_sync  <= '0;
            lrclk_sync <= '0;
            data_sync  <= '0;
            bclk_prev  <= 1'b0;
        end else begin
            bclk_sync  <= {bclk_sync[sync_stages-2:0], i_bclk};
            lrclk_sync <= {lrclk_sync[sync_stages-2:0], i_lrclk};
            data_sync  <= {data_sync[sync_stages-2:0], i_data};
            bclk_prev  <= bclk_sync[sync_stages-1];
        end
    end

    assign bclk_s    = bclk_sync[sync_stages-1];
    assign lr        = lrclk_sync[sync_stages-1];
    assign d         = data_sync[sync_stages-1];
    assign bclk_rise = bclk_s && !bclk_prev;
    assign word_done = bclk_rise && (lr != lr_prev) && aligned;

    // Place the sampled bit at its MSB-first position and form the word that completes on an lr change.
    // NOTE: every always_comb output is given a default first so no latch can be inferred.
    always_comb begin
        d_word = '0;
        for (int i = 0; i < width; i++) begin
            d_word[i] = d && (int'(bit_cnt) == width - 1 - i);
        end
`ifdef I2S_LEFT_JUSTIFIED_EN
        done_word = shift_reg;
`else
        // The change edge still carries the last bit of the finishing slot.
        done_word = shift_reg | d_word;
`endif
    end

`ifdef I2S_LEFT_JUSTIFIED_EN
    logic [width-1:0] d_msb;
    assign d_msb = {d, {(width-1){1'b0}}};
`endif

    // Per-bclk-edge deserialiser: shift bits in, restart the word on every lr change.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lr_prev   <= 1'b0;
            aligned   <= 1'b0;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else if (bclk_rise) begin
            if (lr != lr_prev) begin
                lr_prev <= lr;
                aligned <= 1'b1;
`ifdef I2S_LEFT_JUSTIFIED_EN
                shift_reg <= d_msb;
                bit_cnt   <= cnt_w'(1);
`else
                shift_reg <= '0;
                bit_cnt   <= '0;
`endif
            end else if (bit_cnt < cnt_w'(width)) begin
                shift_reg <= shift_reg | d_word;
                bit_cnt   <= bit_cnt + cnt_w'(1);
            end
        end
    end

    // Output register: load completed words, hold under backpressure, flag dropped words.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_valid   <= 1'b0;
            o_value   <= '0;
            o_is_left <= 1'b0;
            o_overrun <= 1'b0;
        end else if (word_done) begin
            if (o_valid && !o_ready) begin
                o_overrun <= 1'b1;
            end else begin
                o_valid   <= 1'b1;
                o_value   <= done_word;
                o_is_left <= !lr_prev;
            end
        end else if (o_valid && o_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule
